// File: rtl/noc_mem_reader.sv
// NOC read initiator: turns a client address into a memory_read_request packet,
// waits for the matching memory_read_reply and returns the 16-byte line.
package noc_pkg;
  localparam int ID_W  = 8;
  localparam int DAT_W = 128;

  typedef enum logic [2:0] {
    memory_read_request,
    memory_read_reply,
    memory_write_request,
    memory_write_reply
  } pkt_type_t;

  typedef struct packed {
    pkt_type_t        pt;
    logic [ID_W-1:0]  id;
    logic [DAT_W-1:0] dat;
    logic [7:0]       dst_addr;
    logic [3:0]       dst_prt;
    logic [7:0]       src_addr;
    logic [3:0]       src_prt;
  } noc_pkt_t;
endpackage

interface ip_port;
  import noc_pkg::*;
  noc_pkt_t dat_to_noc;
  noc_pkt_t dat_from_noc;
  logic     tx_submit;
  logic     tx_complete;
  logic     rx_recieve;
  logic     rx_complete;

  modport endpoint (
    output dat_to_noc, tx_submit, rx_complete,
    input  dat_from_noc, tx_complete, rx_recieve
  );
  modport stop (
    input  dat_to_noc, tx_submit, rx_complete,
    output dat_from_noc, tx_complete, rx_recieve
  );
endinterface

module noc_mem_reader
  import noc_pkg::*;
#(
  parameter int SRC_ADDR = 1,
  parameter int SRC_PRT  = 0,
  parameter int MEM_ADDR = 2,
  parameter int MEM_PRT  = 0,
  parameter int TIMEOUT  = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [31:0]  req_addr,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [15:0]  stale_cnt,
  ip_port.endpoint     noc
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] id_ctr, cur_id;
  logic [TW-1:0]   tmo_cnt;
  logic            accept, rx_new, rx_match, tmo_hit;
  logic            unused_rx_hdr;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic noc_pkt_t build_req(input logic [31:0] addr, input logic [ID_W-1:0] id);
    noc_pkt_t p;
    p           = '0;
    p.pt        = memory_read_request;
    p.id        = id;
    p.dat[31:0] = addr;
    p.dst_addr  = 8'(MEM_ADDR);
    p.dst_prt   = 4'(MEM_PRT);
    p.src_addr  = 8'(SRC_ADDR);
    p.src_prt   = 4'(SRC_PRT);
    return p;
  endfunction

  // An RX is evaluated only on its first sampled cycle, i.e. before it is acknowledged.
  assign accept   = req_ready && req_valid;
  assign rx_new   = noc.rx_recieve && !noc.rx_complete;
  assign rx_match = rx_new && (state == WAIT_RSP) &&
                    (noc.dat_from_noc.pt == memory_read_reply) &&
                    (noc.dat_from_noc.id == cur_id);
  assign tmo_hit  = (state == WAIT_RSP) && (tmo_cnt == TW'(TIMEOUT - 1));

  // Routing fields of incoming packets carry no information for this endpoint.
  assign unused_rx_hdr = ^{noc.dat_from_noc.dst_addr, noc.dat_from_noc.dst_prt,
                           noc.dat_from_noc.src_addr, noc.dat_from_noc.src_prt};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    noc.tx_submit = (state == SEND);
    rsp_valid     = (state == RESP);
    case (state)
      IDLE:     if (accept) state_nxt = SEND;
      SEND:     if (noc.tx_complete) state_nxt = WAIT_RSP;
      WAIT_RSP: if (rx_match || tmo_hit) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready       <= 1'b0;
      rsp_data        <= '0;
      rsp_err         <= 1'b0;
      stale_cnt       <= '0;
      id_ctr          <= '0;
      cur_id          <= '0;
      tmo_cnt         <= '0;
      noc.dat_to_noc  <= '0;
      noc.rx_complete <= 1'b0;
    end else begin
      req_ready       <= (state_nxt == IDLE);
      noc.rx_complete <= noc.rx_recieve;
      if (rx_new && !rx_match) stale_cnt <= sat_inc(stale_cnt);
      if (accept) begin
        noc.dat_to_noc <= build_req(req_addr, id_ctr);
        cur_id         <= id_ctr;
        id_ctr         <= id_ctr + 1'b1;
      end
      if (state == SEND && noc.tx_complete) tmo_cnt <= '0;
      else if (state == WAIT_RSP)           tmo_cnt <= tmo_cnt + 1'b1;
      // A reply landing on the timeout cycle still wins; on a real timeout the id
      // is burned so a late reply can never match the next request.
      if (rx_match) begin
        rsp_data <= noc.dat_from_noc.dat;
        rsp_err  <= 1'b0;
      end else if (tmo_hit) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
        id_ctr   <= id_ctr + 1'b1;
      end else if (state == RESP) begin
        rsp_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_noc_mem_reader.sv
// Directed bench for noc_mem_reader: the bench acts as NOC stop and loopback memory.
module tb_noc_mem_reader;
  import noc_pkg::*;

  logic         clk, rst, req_valid;
  logic [31:0]  req_addr;
  logic         req_ready, rsp_valid, rsp_err;
  logic [127:0] rsp_data;
  logic [15:0]  stale_cnt;
  int           checks = 0;
  int           errors = 0;
  int           exp_stale = 0;

  ip_port noc();

  noc_mem_reader #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .stale_cnt(stale_cnt), .noc(noc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0]     addr;
    logic [ID_W-1:0] id;
    logic [127:0]    data;
    int              tx_dly;
    bit              keep;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory byte at address A holds A[7:0].
  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 16; k++) l[8*k +: 8] = 8'(a + 32'(k));
    return l;
  endfunction

  function automatic noc_pkt_t mk_pkt(input pkt_type_t t, input logic [ID_W-1:0] id,
                                      input logic [127:0] d);
    noc_pkt_t p;
    p          = '0;
    p.pt       = t;
    p.id       = id;
    p.dat      = d;
    p.dst_addr = 8'd1;
    p.src_addr = 8'd2;
    return p;
  endfunction

  task automatic send_req(input string nm, input logic [31:0] a, input logic [ID_W-1:0] id,
                          input int tx_dly, input bit keep);
    noc_pkt_t tx;
    int       n;
    bit       stable;
    chk({nm, "_ready"}, 128'(req_ready), 128'd1);
    req_valid = 1'b1;
    req_addr  = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!noc.tx_submit && n < 50);
    if (!keep) req_valid = 1'b0;
    chk({nm, "_txlat"}, 128'(n), 128'd1);
    tx = noc.dat_to_noc;
    chk({nm, "_txid"}, 128'(tx.id), 128'(id));
    chk({nm, "_txaddr"}, 128'(tx.dat[31:0]), 128'(a));
    chk({nm, "_txhdr"},
        128'({tx.pt, tx.dst_addr, tx.dst_prt, tx.src_addr, tx.src_prt, tx.dat[127:32]}),
        128'({memory_read_request, 8'd2, 4'd0, 8'd1, 4'd0, 96'd0}));
    chk({nm, "_busy"}, 128'(req_ready), 128'd0);
    if (tx_dly > 0) begin
      stable = 1'b1;
      repeat (tx_dly) begin
        @(negedge clk);
        if (!noc.tx_submit || noc.dat_to_noc !== tx || rsp_valid) stable = 1'b0;
      end
      chk({nm, "_txhold"}, 128'(stable), 128'd1);
    end
  endtask

  task automatic tx_done(input string nm);
    noc.tx_complete = 1'b1;
    @(negedge clk);
    noc.tx_complete = 1'b0;
    chk({nm, "_txoff"}, 128'(noc.tx_submit), 128'd0);
  endtask

  task automatic rx_xfer(input string nm, input noc_pkt_t p, output logic v,
                         output logic [127:0] d, output logic e);
    noc.dat_from_noc = p;
    noc.rx_recieve   = 1'b1;
    @(negedge clk);
    v = rsp_valid;
    d = rsp_data;
    e = rsp_err;
    chk({nm, "_rxack"}, 128'(noc.rx_complete), 128'd1);
    noc.rx_recieve = 1'b0;
    @(negedge clk);
    chk({nm, "_rxdrop"}, 128'(noc.rx_complete), 128'd0);
    chk({nm, "_rsp1cyc"}, 128'(rsp_valid), 128'd0);
  endtask

  task automatic do_read(input string nm, input logic [31:0] a, input logic [ID_W-1:0] id,
                         input logic [127:0] exp, input int tx_dly, input int w_dly,
                         input bit keep);
    logic         v, e;
    logic [127:0] d;
    send_req(nm, a, id, tx_dly, keep);
    tx_done(nm);
    repeat (w_dly) @(negedge clk);
    rx_xfer(nm, mk_pkt(memory_read_reply, id, mem_line(a)), v, d, e);
    chk({nm, "_valid"}, 128'(v), 128'd1);
    chk({nm, "_err"}, 128'(e), 128'd0);
    chk({nm, "_data"}, d, exp);
    chk({nm, "_stale"}, 128'(stale_cnt), 128'(exp_stale));
  endtask

  initial begin
    logic         v, e;
    logic [127:0] d;
    int           n;
    bit           seen;

    rst = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    noc.tx_complete  = 1'b0;
    noc.rx_recieve   = 1'b0;
    noc.dat_from_noc = '0;

    tbl[0] = '{addr: 32'h0000_0000, id: 8'd0, data: 128'h0F0E0D0C_0B0A0908_07060504_03020100, tx_dly: 0,  keep: 1'b1};
    tbl[1] = '{addr: 32'h0000_0010, id: 8'd1, data: 128'h1F1E1D1C_1B1A1918_17161514_13121110, tx_dly: 0,  keep: 1'b1};
    tbl[2] = '{addr: 32'h0000_0020, id: 8'd2, data: 128'h2F2E2D2C_2B2A2928_27262524_23222120, tx_dly: 0,  keep: 1'b1};
    tbl[3] = '{addr: 32'h0000_01F0, id: 8'd3, data: 128'hFFFEFDFC_FBFAF9F8_F7F6F5F4_F3F2F1F0, tx_dly: 20, keep: 1'b1};
    tbl[4] = '{addr: 32'h0001_23A5, id: 8'd4, data: 128'hB4B3B2B1_B0AFAEAD_ACABAAA9_A8A7A6A5, tx_dly: 0,  keep: 1'b0};

    #1 rst = 1'b0;
    #2;
    chk("rst_ready", 128'(req_ready), 128'd0);
    chk("rst_valid", 128'(rsp_valid), 128'd0);
    chk("rst_err", 128'(rsp_err), 128'd0);
    chk("rst_data", rsp_data, 128'd0);
    chk("rst_txsub", 128'(noc.tx_submit), 128'd0);
    chk("rst_rxcmp", 128'(noc.rx_complete), 128'd0);
    chk("rst_pkt", 128'(|noc.dat_to_noc), 128'd0);
    chk("rst_stale", 128'(stale_cnt), 128'd0);
    repeat (2) @(negedge clk);
    chk("rst_hold", 128'(req_ready), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rel", 128'(req_ready), 128'd1);

    // Back-to-back reads with req_valid held high through the first four responses.
    for (int i = 0; i < 5; i++)
      do_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].id, tbl[i].data,
              tbl[i].tx_dly, 0, tbl[i].keep);

    // Reply arriving with tx_complete in SEND, then foreign and wrong-id packets, then the match.
    send_req("stale", 32'h40, 8'd5, 0, 1'b0);
    noc.dat_from_noc = mk_pkt(memory_read_reply, 8'd5, mem_line(32'h40));
    noc.tx_complete  = 1'b1;
    noc.rx_recieve   = 1'b1;
    @(negedge clk);
    noc.tx_complete = 1'b0;
    exp_stale++;
    chk("same_txoff", 128'(noc.tx_submit), 128'd0);
    chk("same_ack", 128'(noc.rx_complete), 128'd1);
    chk("same_norsp", 128'(rsp_valid), 128'd0);
    noc.rx_recieve = 1'b0;
    @(negedge clk);
    chk("same_drop", 128'(noc.rx_complete), 128'd0);
    chk("same_stale", 128'(stale_cnt), 128'(exp_stale));
    rx_xfer("wr", mk_pkt(memory_write_request, 8'd5, mem_line(32'h40)), v, d, e);
    exp_stale++;
    chk("wr_norsp", 128'(v), 128'd0);
    chk("wr_stale", 128'(stale_cnt), 128'(exp_stale));
    rx_xfer("id4", mk_pkt(memory_read_reply, 8'd4, mem_line(32'h40)), v, d, e);
    exp_stale++;
    chk("id4_norsp", 128'(v), 128'd0);
    chk("id4_stale", 128'(stale_cnt), 128'(exp_stale));
    rx_xfer("id5", mk_pkt(memory_read_reply, 8'd5, mem_line(32'h40)), v, d, e);
    chk("id5_valid", 128'(v), 128'd1);
    chk("id5_err", 128'(e), 128'd0);
    chk("id5_data", d, 128'h4F4E4D4C_4B4A4948_47464544_43424140);
    chk("id5_stale", 128'(stale_cnt), 128'(exp_stale));

    // No reply: error response 8 cycles after entering WAIT_RSP, late reply is drained.
    send_req("tmo", 32'h50, 8'd6, 0, 1'b0);
    tx_done("tmo");
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_lat", 128'(n), 128'd9);
    chk("tmo_err", 128'(rsp_err), 128'd1);
    chk("tmo_data", rsp_data, 128'd0);
    @(negedge clk);
    chk("tmo_once", 128'(rsp_valid), 128'd0);
    rx_xfer("late", mk_pkt(memory_read_reply, 8'd6, mem_line(32'h50)), v, d, e);
    exp_stale++;
    chk("late_norsp", 128'(v), 128'd0);
    chk("late_stale", 128'(stale_cnt), 128'(exp_stale));

    // Timeout burned id 7; the match is sampled on the timeout cycle and must win.
    do_read("tie", 32'h60, 8'd8, 128'h6F6E6D6C_6B6A6968_67666564_63626160, 0, 7, 1'b0);

    // Asynchronous reset in the middle of SEND.
    send_req("rst2", 32'h70, 8'd9, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    exp_stale = 0;
    chk("rst2_txsub", 128'(noc.tx_submit), 128'd0);
    chk("rst2_ready", 128'(req_ready), 128'd0);
    chk("rst2_valid", 128'(rsp_valid), 128'd0);
    chk("rst2_stale", 128'(stale_cnt), 128'd0);
    @(negedge clk);
    rst  = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst2_norsp", 128'(seen), 128'd0);
    chk("rst2_ready1", 128'(req_ready), 128'd1);
    do_read("postrst", 32'h80, 8'd0, 128'h8F8E8D8C_8B8A8988_87868584_83828180, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
